// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial pattern detector.
// Bits shift MSB-first into a PATTERN_W window. Once the window is full,
// each consumed bit is compared against a runtime-loadable pattern.
// Overlapping or flushing behaviour is selectable per bit. Matches feed a
// saturating counter.
//
// Input qualifier: bit_in is consumed on a rising clk edge only when
// bit_valid=1, en=1 and load=0. There is no back-pressure; the detector
// always accepts a valid bit. bit_valid=0 cycles are gaps that leave the
// window, fill count and state untouched.
module seq_detect_param #(
  parameter int unsigned PATTERN_W = 8,
  parameter int unsigned CNT_W     = 8,
  parameter logic [PATTERN_W-1:0] RST_PATTERN = PATTERN_W'('hA5)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [PATTERN_W-1:0] pattern_in,
  input  logic                 overlap,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 clr_count,
  output logic                 match,
  output logic [CNT_W-1:0]     match_count,
  output logic [1:0]           state,
  output logic [PATTERN_W-1:0] window
);

  localparam int unsigned FW = $clog2(PATTERN_W + 1);
  localparam logic [FW-1:0]    FILL_FULL = FW'(PATTERN_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_HUNT = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [PATTERN_W-1:0] window_q, window_d;
  logic [PATTERN_W-1:0] pattern_q, pattern_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic                 match_q, match_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // Bit acceptance and the compare against the pattern. These are shared by
  // the next-state and datapath logic.
  logic                 consume;
  logic [PATTERN_W-1:0] win_shift;
  logic [FW-1:0]        fill_inc;
  logic                 full_next;
  logic                 hit;

  // Decode whether a bit is consumed this cycle and whether it completes a match.
  always_comb begin
    consume   = en && !load && bit_valid;
    win_shift = {window_q[PATTERN_W-2:0], bit_in};
    fill_inc  = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
    full_next = (fill_inc == FILL_FULL);
    hit       = consume && full_next && (win_shift == pattern_q);
  end

  // State register plus the registered datapath, with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      window_q  <= '0;
      pattern_q <= RST_PATTERN;
      fill_q    <= '0;
      match_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      window_q  <= window_d;
      pattern_q <= pattern_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      count_q   <= count_d;
    end
  end

  // Next-state logic. Priority is en=0, then load, then a consumed bit.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else if (load) begin
      state_d = ST_FILL;
    end else if (consume) begin
      if (hit && !overlap) begin
        // A non-overlapping match restarts the fill from an empty window.
        state_d = ST_FILL;
      end else if (full_next) begin
        state_d = ST_HUNT;
      end else begin
        state_d = ST_FILL;
      end
    end else if (state_q == ST_IDLE) begin
      state_d = ST_FILL;
    end
  end

  // Datapath update: window, fill, pattern, match pulse and counter.
  always_comb begin
    window_d  = window_q;
    fill_d    = fill_q;
    pattern_d = load ? pattern_in : pattern_q;
    match_d   = hit;
    if (!en || load) begin
      window_d = '0;
      fill_d   = '0;
    end else if (consume) begin
      if (hit && !overlap) begin
        window_d = '0;
        fill_d   = '0;
      end else begin
        window_d = win_shift;
        fill_d   = fill_inc;
      end
    end
    // A clear that lands together with a match still counts that match.
    if (clr_count) begin
      count_d = hit ? CNT_W'(1) : '0;
    end else if (hit && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Drive the ports from the registered state.
  always_comb begin
    match       = match_q;
    match_count = count_q;
    state       = state_q;
    window      = window_q;
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param with PATTERN_W=4, CNT_W=4 and a reset
// pattern of 4'h5 (the low nibble of 'hA5).
module tb_seq_detect_param;

  localparam int unsigned PW = 4;
  localparam int unsigned CW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [PW-1:0] pattern_in = '0;
  logic          overlap = 1'b1;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          clr_count = 1'b0;
  logic          match;
  logic [CW-1:0] match_count;
  logic [1:0]    state;
  logic [PW-1:0] window;

  seq_detect_param #(
    .PATTERN_W  (PW),
    .CNT_W      (CW),
    .RST_PATTERN(4'h5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .pattern_in (pattern_in),
    .overlap    (overlap),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .clr_count  (clr_count),
    .match      (match),
    .match_count(match_count),
    .state      (state),
    .window     (window)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // scoreboard of expected match flags for streamed bits
  logic [0:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge, outputs
  // are sampled at the same point.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    cycle();
    bit_valid = 1'b0;
  endtask

  task automatic do_load(input logic [PW-1:0] p);
    pattern_in = p;
    load       = 1'b1;
    cycle();
    load       = 1'b0;
  endtask

  // Stream a nibble MSB-first and check every match pulse against exp_q.
  task automatic stream(input string tag, input logic [6:0] bits, input int n,
                        input logic [6:0] exp_m);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_m[n-1-i]);
    for (int i = 0; i < n; i++) begin
      send_bit(bits[n-1-i]);
      chk($sformatf("%s_match_b%0d", tag, i + 1), 32'(match), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    // reset state
    cycle();
    cycle();
    chk("rst_match", 32'(match), 0);
    chk("rst_count", 32'(match_count), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_window", 32'(window), 0);
    rst = 1'b0;
    cycle();

    // T1: overlapping detection of 1011 in 1011011
    en = 1'b1;
    overlap = 1'b1;
    do_load(4'b1011);
    chk("t1_state_load", 32'(state), 1);
    chk("t1_window_load", 32'(window), 0);
    stream("t1", 7'b1011011, 7, 7'b0001001);
    chk("t1_window", 32'(window), 32'b1011);
    chk("t1_state", 32'(state), 2);
    chk("t1_count", 32'(match_count), 2);
    cycle();
    chk("t1_pulse_end", 32'(match), 0);

    // T2: non-overlapping, same stream
    clr_count = 1'b1;
    cycle();
    clr_count = 1'b0;
    chk("t2_clr", 32'(match_count), 0);
    overlap = 1'b0;
    do_load(4'b1011);
    stream("t2a", 7'b1011, 4, 7'b0001);
    chk("t2_state_after", 32'(state), 1);
    chk("t2_window_after", 32'(window), 0);
    chk("t2_count_after", 32'(match_count), 1);
    stream("t2b", 7'b011, 3, 7'b000);
    chk("t2_window_end", 32'(window), 32'b0011);
    chk("t2_count_end", 32'(match_count), 1);

    // T3: gaps between bits, then load with a simultaneous valid bit
    overlap = 1'b1;
    do_load(4'b1011);
    send_bit(1'b1);
    cycle();
    cycle();
    chk("t3_gap_window", 32'(window), 32'b0001);
    send_bit(1'b0);
    cycle();
    chk("t3_gap_state", 32'(state), 1);
    send_bit(1'b1);
    cycle();
    cycle();
    cycle();
    chk("t3_gap_window2", 32'(window), 32'b0101);
    chk("t3_gap_match0", 32'(match), 0);
    send_bit(1'b1);
    chk("t3_match", 32'(match), 1);
    chk("t3_count", 32'(match_count), 2);
    cycle();
    chk("t3_pulse_end", 32'(match), 0);
    pattern_in = 4'b0110;
    load       = 1'b1;
    bit_in     = 1'b1;
    bit_valid  = 1'b1;
    cycle();
    load       = 1'b0;
    bit_valid  = 1'b0;
    chk("t3_load_window", 32'(window), 0);
    chk("t3_load_state", 32'(state), 1);
    chk("t3_load_match", 32'(match), 0);
    chk("t3_load_count", 32'(match_count), 2);
    stream("t3_new", 7'b0110, 4, 7'b0001);
    chk("t3_new_count", 32'(match_count), 3);

    // T4: saturation with 20 ones on pattern 1111, then clear plus match
    clr_count = 1'b1;
    do_load(4'b1111);
    clr_count = 1'b0;
    chk("t4_clr", 32'(match_count), 0);
    for (int k = 1; k <= 20; k++) begin
      send_bit(1'b1);
      chk($sformatf("t4_match_b%0d", k), 32'(match), (k >= 4) ? 1 : 0);
      chk($sformatf("t4_count_b%0d", k), 32'(match_count),
          (k < 4) ? 0 : ((k - 3 > 15) ? 15 : k - 3));
    end
    clr_count = 1'b1;
    send_bit(1'b1);
    clr_count = 1'b0;
    chk("t4_clr_match", 32'(match), 1);
    chk("t4_clr_count", 32'(match_count), 1);

    // T5: enable drop mid-window, then asynchronous reset
    do_load(4'b1011);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("t5_window_2b", 32'(window), 32'b0010);
    en = 1'b0;
    send_bit(1'b1);
    chk("t5_idle_state", 32'(state), 0);
    chk("t5_idle_window", 32'(window), 0);
    chk("t5_idle_count", 32'(match_count), 1);
    send_bit(1'b1);
    chk("t5_idle_ignore", 32'(window), 0);
    en = 1'b1;
    cycle();
    chk("t5_reenable", 32'(state), 1);
    stream("t5_pre", 7'b1011, 4, 7'b0001);
    chk("t5_pre_count", 32'(match_count), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_arst_match", 32'(match), 0);
    chk("t5_arst_count", 32'(match_count), 0);
    chk("t5_arst_state", 32'(state), 0);
    chk("t5_arst_window", 32'(window), 0);
    #1;
    rst = 1'b0;
    cycle();
    chk("t5_post_state", 32'(state), 1);
    stream("t5_post", 7'b1011010, 7, 7'b0000000);
    send_bit(1'b1);
    chk("t5_rstpat_match", 32'(match), 1);
    chk("t5_rstpat_count", 32'(match_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
